// File: rtl/mux6_pkg.sv
// mux6_pkg: shared constants for the six-input mux selector interface.
// Holds the sparse selector codes, the index-to-code lookup, the arbiter
// state enum and the number of inputs.
package mux6_pkg;

  localparam int N_ENTRADAS = 6;

  localparam logic [3:0] SEL_ENTRADA1 = 4'b0000;
  localparam logic [3:0] SEL_ENTRADA2 = 4'b0001;
  localparam logic [3:0] SEL_ENTRADA3 = 4'b0010;
  localparam logic [3:0] SEL_ENTRADA4 = 4'b0110;
  localparam logic [3:0] SEL_ENTRADA5 = 4'b0111;
  localparam logic [3:0] SEL_ENTRADA6 = 4'b1100;

  typedef enum logic {
    OCIOSO    = 1'b0,
    CONCEDIDO = 1'b1
  } estado_t;

  // Index-to-code lookup; out-of-range indices fall back to entrada1's code
  // so no code outside the table can ever be produced.
  function automatic logic [3:0] codigo_seletor(input logic [2:0] indice);
    logic [3:0] codigo;
    case (indice)
      3'd0:    codigo = SEL_ENTRADA1;
      3'd1:    codigo = SEL_ENTRADA2;
      3'd2:    codigo = SEL_ENTRADA3;
      3'd3:    codigo = SEL_ENTRADA4;
      3'd4:    codigo = SEL_ENTRADA5;
      3'd5:    codigo = SEL_ENTRADA6;
      default: codigo = SEL_ENTRADA1;
    endcase
    return codigo;
  endfunction

endpackage

// File: rtl/arbitro_seletor6_if.sv
// arbitro_seletor6_if: request/grant/selector bundle between the six
// requesters and the arbiter. The arbiter is the slave side: it receives
// requests and the release strobe and drives the selector and grant.
interface arbitro_seletor6_if;

  logic [5:0] requisicao;
  logic       liberar;
  logic [3:0] seletor;
  logic [5:0] concessao;
  logic       concedido;

  modport slave (
    input  requisicao,
    input  liberar,
    output seletor,
    output concessao,
    output concedido
  );

  modport master (
    output requisicao,
    output liberar,
    input  seletor,
    input  concessao,
    input  concedido
  );

endinterface

// File: rtl/prioridade6.sv
// prioridade6: combinational rotating-priority picker. Starting at the
// pointer and searching upward modulo six, the first raised request wins.
module prioridade6
  import mux6_pkg::*;
(
  input  logic [5:0] requisicao,
  input  logic [2:0] ponteiro,
  output logic [5:0] vencedor,
  output logic [2:0] indice,
  output logic       algum
);

  // Scan the six positions in priority order and keep the first hit.
  always_comb begin
    logic       achou;
    logic [2:0] cand;
    vencedor = '0;
    indice   = '0;
    achou    = 1'b0;
    cand     = '0;
    for (int i = 0; i < N_ENTRADAS; i++) begin
      cand = 3'((int'(ponteiro) + i) % N_ENTRADAS);
      if (!achou && requisicao[cand]) begin
        achou          = 1'b1;
        indice         = cand;
        vencedor[cand] = 1'b1;
      end
    end
  end

  assign algum = |requisicao;

endmodule

// File: rtl/arbitro_seletor6.sv
// arbitro_seletor6: round-robin arbiter and encoder producing the sparse
// 4-bit selector code for mux6_1. A grant is held until liberar, until the
// granted request drops, or until HOLD_MAX cycles have elapsed, and every
// grant is followed by one idle cycle.
// Configuration macro: ARBITRO_ROUND_ROBIN_EN (defined = rotating priority,
// undefined = fixed priority with entrada1 highest).
module arbitro_seletor6
  import mux6_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  arbitro_seletor6_if.slave     bus
);

  localparam logic       TEMPO_ATIVO = (HOLD_MAX != 0);
  localparam logic [7:0] LIMITE      = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

  estado_t    estado;
  logic [2:0] ponteiro;
  logic [7:0] contador;
  logic [3:0] seletor_q;
  logic [5:0] concessao_q;
  logic       concedido_q;

  logic [5:0] vencedor;
  logic [2:0] indice_venc;
  logic       algum;
  logic       pedido_caiu;
  logic       tempo_esgotado;
  logic       liberacao;
  logic [2:0] proximo_ponteiro;

  prioridade6 u_prioridade (
    .requisicao (bus.requisicao),
    .ponteiro   (ponteiro),
    .vencedor   (vencedor),
    .indice     (indice_venc),
    .algum      (algum)
  );

  assign pedido_caiu    = (bus.requisicao & concessao_q) == 6'b000000;
  assign tempo_esgotado = TEMPO_ATIVO && (contador == LIMITE);
  assign liberacao      = bus.liberar || pedido_caiu || tempo_esgotado;

`ifdef ARBITRO_ROUND_ROBIN_EN
  // Pointer after a release is the position just above the current holder.
  function automatic logic [2:0] ponteiro_apos(input logic [5:0] grant);
    logic [2:0] prox;
    case (grant)
      6'b000001: prox = 3'd1;
      6'b000010: prox = 3'd2;
      6'b000100: prox = 3'd3;
      6'b001000: prox = 3'd4;
      6'b010000: prox = 3'd5;
      default:   prox = 3'd0;
    endcase
    return prox;
  endfunction

  assign proximo_ponteiro = ponteiro_apos(concessao_q);
`else
  assign proximo_ponteiro = 3'd0;
`endif

  // Grant FSM with pointer, saturating hold counter and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado      <= OCIOSO;
      ponteiro    <= 3'd0;
      contador    <= 8'd0;
      seletor_q   <= SEL_ENTRADA1;
      concessao_q <= 6'b000000;
      concedido_q <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (algum) begin
            estado      <= CONCEDIDO;
            seletor_q   <= codigo_seletor(indice_venc);
            concessao_q <= vencedor;
            concedido_q <= 1'b1;
            contador    <= 8'd0;
          end
        end
        CONCEDIDO: begin
          if (liberacao) begin
            estado      <= OCIOSO;
            concessao_q <= 6'b000000;
            concedido_q <= 1'b0;
            ponteiro    <= proximo_ponteiro;
          end else if (contador != 8'hFF) begin
            contador <= contador + 8'd1;
          end
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.seletor   = seletor_q;
  assign bus.concessao = concessao_q;
  assign bus.concedido = concedido_q;

endmodule
